// File: rtl/axi_rd_arbiter_if.sv
// AR/R bundle between two read masters, the arbiter and one slave.
// The arbiter binds the slave modport; the surrounding fabric binds master.
interface axi_rd_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 4
);
   logic [ADDR_W-1:0] M0_ARADDR, M1_ARADDR;
   logic [LEN_W-1:0]  M0_ARLEN, M1_ARLEN;
   logic [2:0]        M0_ARSIZE, M1_ARSIZE;
   logic [1:0]        M0_ARBURST, M1_ARBURST;
   logic              M0_ARVALID, M1_ARVALID;
   logic              ARREADY_M0, ARREADY_M1;
   logic [DATA_W-1:0] RDATA_M0, RDATA_M1;
   logic [1:0]        RRESP_M0, RRESP_M1;
   logic              RLAST_M0, RLAST_M1;
   logic              RVALID_M0, RVALID_M1;
   logic              M0_RREADY, M1_RREADY;
   logic [ADDR_W-1:0] ARADDR_S;
   logic [LEN_W-1:0]  ARLEN_S;
   logic [2:0]        ARSIZE_S;
   logic [1:0]        ARBURST_S;
   logic              ARVALID_S;
   logic              S_ARREADY;
   logic [DATA_W-1:0] S_RDATA;
   logic [1:0]        S_RRESP;
   logic              S_RLAST;
   logic              S_RVALID;
   logic              RREADY_S;

   modport slave (
      input  M0_ARADDR, M1_ARADDR, M0_ARLEN, M1_ARLEN,
      input  M0_ARSIZE, M1_ARSIZE, M0_ARBURST, M1_ARBURST,
      input  M0_ARVALID, M1_ARVALID, M0_RREADY, M1_RREADY,
      input  S_ARREADY, S_RDATA, S_RRESP, S_RLAST, S_RVALID,
      output ARREADY_M0, ARREADY_M1,
      output RDATA_M0, RDATA_M1, RRESP_M0, RRESP_M1,
      output RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1,
      output ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S,
      output ARVALID_S, RREADY_S
   );

   modport master (
      output M0_ARADDR, M1_ARADDR, M0_ARLEN, M1_ARLEN,
      output M0_ARSIZE, M1_ARSIZE, M0_ARBURST, M1_ARBURST,
      output M0_ARVALID, M1_ARVALID, M0_RREADY, M1_RREADY,
      output S_ARREADY, S_RDATA, S_RRESP, S_RLAST, S_RVALID,
      input  ARREADY_M0, ARREADY_M1,
      input  RDATA_M0, RDATA_M1, RRESP_M0, RRESP_M1,
      input  RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1,
      input  ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S,
      input  ARVALID_S, RREADY_S
   );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-master round-robin AXI4 read arbiter, one outstanding burst.
// Owner holds the slave until its RLAST beat; beat count checked vs ARLEN.
module axi_rd_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 4
) (
   input  logic            G_clk,
   input  logic            G_reset,
   axi_rd_arbiter_if.slave bus,
   output logic            owner,
   output logic            busy,
   output logic            len_err
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
      logic [2:0]        size;
      logic [1:0]        burst;
   } ar_t;

   state_t         state, state_nx;
   ar_t            ar_q, ar_nx, m0_ar, m1_ar, win_ar;
   logic           prio, prio_nx, owner_nx;
   logic           arvalid_q, arvalid_nx, len_err_nx;
   logic [LEN_W:0] cnt, cnt_nx;
   logic           winner, req, accept, beat, in_data;
   logic           own_rdy;

   assign m0_ar = {bus.M0_ARADDR, bus.M0_ARLEN,
                   bus.M0_ARSIZE, bus.M0_ARBURST};
   assign m1_ar = {bus.M1_ARADDR, bus.M1_ARLEN,
                   bus.M1_ARSIZE, bus.M1_ARBURST};

   assign req    = bus.M0_ARVALID | bus.M1_ARVALID;
   assign winner = (bus.M0_ARVALID & bus.M1_ARVALID) ?
                   prio : bus.M1_ARVALID;
   assign win_ar = winner ? m1_ar : m0_ar;

   // Gated by reset so no grant is advertised while held in reset.
   assign accept = G_reset & (state == IDLE) & req;

   assign bus.ARREADY_M0 = accept & ~winner;
   assign bus.ARREADY_M1 = accept & winner;

   assign in_data      = (state == DATA);
   assign own_rdy      = owner ? bus.M1_RREADY : bus.M0_RREADY;
   assign bus.RREADY_S = in_data & own_rdy;
   assign beat         = bus.S_RVALID & bus.RREADY_S;

   assign bus.RVALID_M0 = in_data & ~owner & bus.S_RVALID;
   assign bus.RVALID_M1 = in_data & owner & bus.S_RVALID;
   assign bus.RLAST_M0  = in_data & ~owner & bus.S_RLAST;
   assign bus.RLAST_M1  = in_data & owner & bus.S_RLAST;
   assign bus.RDATA_M0  = (in_data & ~owner) ? bus.S_RDATA : '0;
   assign bus.RDATA_M1  = (in_data & owner) ? bus.S_RDATA : '0;
   assign bus.RRESP_M0  = (in_data & ~owner) ? bus.S_RRESP : '0;
   assign bus.RRESP_M1  = (in_data & owner) ? bus.S_RRESP : '0;

   assign bus.ARVALID_S = arvalid_q;
   assign bus.ARADDR_S  = ar_q.addr;
   assign bus.ARLEN_S   = ar_q.len;
   assign bus.ARSIZE_S  = ar_q.size;
   assign bus.ARBURST_S = ar_q.burst;

   assign busy = (state != IDLE);

   always_comb begin
      state_nx   = state;
      ar_nx      = ar_q;
      owner_nx   = owner;
      prio_nx    = prio;
      cnt_nx     = cnt;
      arvalid_nx = arvalid_q;
      len_err_nx = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               ar_nx      = win_ar;
               owner_nx   = winner;
               cnt_nx     = '0;
               arvalid_nx = 1'b1;
               state_nx   = ADDR;
            end
         end
         ADDR: begin
            if (bus.S_ARREADY) begin
               arvalid_nx = 1'b0;
               state_nx   = DATA;
            end
         end
         DATA: begin
            if (beat) begin
               // Saturate so runaway bursts never alias a legal count.
               if (~&cnt) cnt_nx = cnt + {{LEN_W{1'b0}}, 1'b1};
               if (bus.S_RLAST) begin
                  state_nx   = IDLE;
                  prio_nx    = ~owner;
                  len_err_nx = (cnt != {1'b0, ar_q.len});
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge G_clk or negedge G_reset) begin
      if (!G_reset) begin
         state     <= IDLE;
         ar_q      <= '0;
         owner     <= 1'b0;
         prio      <= 1'b0;
         cnt       <= '0;
         arvalid_q <= 1'b0;
         len_err   <= 1'b0;
      end else begin
         state     <= state_nx;
         ar_q      <= ar_nx;
         owner     <= owner_nx;
         prio      <= prio_nx;
         cnt       <= cnt_nx;
         arvalid_q <= arvalid_nx;
         len_err   <= len_err_nx;
      end
   end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios plus randomized bursts
// checked against a grant/beat model of two masters and one slave.
module tb_axi_rd_arbiter;
   logic G_clk;
   logic G_reset;
   logic owner, busy, len_err;
   int   n_chk;
   int   n_pass;
   logic mprio;

   axi_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(4)) bus ();

   axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(4)) dut (
      .G_clk   (G_clk),
      .G_reset (G_reset),
      .bus     (bus),
      .owner   (owner),
      .busy    (busy),
      .len_err (len_err)
   );

   initial G_clk = 1'b0;
   always #5 G_clk = ~G_clk;

   task automatic step();
      @(posedge G_clk);
      #1;
   endtask

   task automatic clear_in();
      bus.M0_ARADDR = '0; bus.M1_ARADDR = '0;
      bus.M0_ARLEN = '0; bus.M1_ARLEN = '0;
      bus.M0_ARSIZE = '0; bus.M1_ARSIZE = '0;
      bus.M0_ARBURST = '0; bus.M1_ARBURST = '0;
      bus.M0_ARVALID = 1'b0; bus.M1_ARVALID = 1'b0;
      bus.M0_RREADY = 1'b0; bus.M1_RREADY = 1'b0;
      bus.S_ARREADY = 1'b0; bus.S_RDATA = '0;
      bus.S_RRESP = '0; bus.S_RLAST = 1'b0; bus.S_RVALID = 1'b0;
   endtask

   task automatic drive_req(input logic m, input logic v,
                            input logic [31:0] a, input logic [3:0] l,
                            input logic [2:0] sz, input logic [1:0] bt);
      if (m) begin
         bus.M1_ARADDR = a; bus.M1_ARLEN = l; bus.M1_ARSIZE = sz;
         bus.M1_ARBURST = bt; bus.M1_ARVALID = v;
      end else begin
         bus.M0_ARADDR = a; bus.M0_ARLEN = l; bus.M0_ARSIZE = sz;
         bus.M0_ARBURST = bt; bus.M0_ARVALID = v;
      end
   endtask

   task automatic drop(input logic m);
      if (m) bus.M1_ARVALID = 1'b0;
      else bus.M0_ARVALID = 1'b0;
   endtask

   task automatic set_rready(input logic m, input logic r);
      if (m) bus.M1_RREADY = r;
      else bus.M0_RREADY = r;
   endtask

   task automatic addr_phase();
      bus.S_ARREADY = 1'b1;
      step();
      bus.S_ARREADY = 1'b0;
   endtask

   task automatic beats(input logic m, input int n, input logic [31:0] base);
      set_rready(m, 1'b1);
      bus.S_RVALID = 1'b1;
      for (int i = 0; i < n; i++) begin
         bus.S_RDATA = base + 32'(i);
         bus.S_RLAST = (i == n - 1);
         step();
      end
      bus.S_RVALID = 1'b0;
      bus.S_RLAST = 1'b0;
      set_rready(m, 1'b0);
   endtask

   task automatic do_reset();
      G_reset = 1'b0;
      clear_in();
      repeat (2) step();
      G_reset = 1'b1;
      step();
      mprio = 1'b0;
   endtask

   task automatic test_reset();
      G_reset = 1'b0;
      clear_in();
      bus.M0_ARVALID = 1'b1; bus.M1_ARVALID = 1'b1;
      bus.S_RVALID = 1'b1; bus.M0_RREADY = 1'b1;
      step();
      n_chk++; if (bus.ARREADY_M0 !== 1'b0) $display("FAIL rst_arready0 got %b want 0", bus.ARREADY_M0); else n_pass++;
      n_chk++; if (bus.ARREADY_M1 !== 1'b0) $display("FAIL rst_arready1 got %b want 0", bus.ARREADY_M1); else n_pass++;
      n_chk++; if (bus.ARVALID_S !== 1'b0) $display("FAIL rst_arvalid_s got %b want 0", bus.ARVALID_S); else n_pass++;
      n_chk++; if (bus.RREADY_S !== 1'b0) $display("FAIL rst_rready_s got %b want 0", bus.RREADY_S); else n_pass++;
      n_chk++; if (bus.RVALID_M0 !== 1'b0) $display("FAIL rst_rvalid0 got %b want 0", bus.RVALID_M0); else n_pass++;
      n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
      n_chk++; if (owner !== 1'b0) $display("FAIL rst_owner got %b want 0", owner); else n_pass++;
      n_chk++; if (len_err !== 1'b0) $display("FAIL rst_len_err got %b want 0", len_err); else n_pass++;
      n_chk++; if (bus.ARADDR_S !== 32'h0) $display("FAIL rst_araddr_s got %h want 0", bus.ARADDR_S); else n_pass++;
      clear_in();
      G_reset = 1'b1;
      step();
      // M0 burst completes so priority points to M1 before the abort
      drive_req(0, 1, 32'h100, 4'd0, 3'd2, 2'd1);
      step(); drop(0); addr_phase(); beats(0, 1, 32'h5);
      drive_req(1, 1, 32'h200, 4'd3, 3'd2, 2'd1);
      step(); drop(1); addr_phase();
      n_chk++; if (owner !== 1'b1) $display("FAIL rst_mid_owner got %b want 1", owner); else n_pass++;
      n_chk++; if (busy !== 1'b1) $display("FAIL rst_mid_busy got %b want 1", busy); else n_pass++;
      bus.S_RVALID = 1'b1; bus.M1_RREADY = 1'b1; bus.S_RDATA = 32'hDEAD;
      #1;
      n_chk++; if (bus.RREADY_S !== 1'b1) $display("FAIL rst_mid_rready got %b want 1", bus.RREADY_S); else n_pass++;
      G_reset = 1'b0;
      step();
      G_reset = 1'b1;
      bus.M0_ARVALID = 1'b1; bus.M1_ARVALID = 1'b1;
      #1;
      n_chk++; if (busy !== 1'b0) $display("FAIL rst_after_busy got %b want 0", busy); else n_pass++;
      n_chk++; if (bus.ARVALID_S !== 1'b0) $display("FAIL rst_after_arvalid got %b want 0", bus.ARVALID_S); else n_pass++;
      n_chk++; if (bus.RREADY_S !== 1'b0) $display("FAIL rst_after_rready got %b want 0", bus.RREADY_S); else n_pass++;
      n_chk++; if (bus.RVALID_M1 !== 1'b0) $display("FAIL rst_after_rvalid1 got %b want 0", bus.RVALID_M1); else n_pass++;
      n_chk++; if (owner !== 1'b0) $display("FAIL rst_after_owner got %b want 0", owner); else n_pass++;
      n_chk++; if (bus.ARREADY_M0 !== 1'b1) $display("FAIL rst_after_prio0 got %b want 1", bus.ARREADY_M0); else n_pass++;
      n_chk++; if (bus.ARREADY_M1 !== 1'b0) $display("FAIL rst_after_prio1 got %b want 0", bus.ARREADY_M1); else n_pass++;
      clear_in();
      step();
      mprio = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      drive_req(0, 1, 32'h0000_1000, 4'd3, 3'd2, 2'd1);
      bus.S_ARREADY = 1'b1;
      #1;
      n_chk++; if (bus.ARREADY_M0 !== 1'b1) $display("FAIL single_arready0 got %b want 1", bus.ARREADY_M0); else n_pass++;
      n_chk++; if (bus.ARVALID_S !== 1'b0) $display("FAIL single_arvalid_c0 got %b want 0", bus.ARVALID_S); else n_pass++;
      step();
      drop(0);
      #1;
      n_chk++; if (bus.ARVALID_S !== 1'b1) $display("FAIL single_arvalid_c1 got %b want 1", bus.ARVALID_S); else n_pass++;
      n_chk++; if (bus.ARADDR_S !== 32'h1000) $display("FAIL single_araddr got %h want 1000", bus.ARADDR_S); else n_pass++;
      n_chk++; if (bus.ARLEN_S !== 4'd3) $display("FAIL single_arlen got %0d want 3", bus.ARLEN_S); else n_pass++;
      n_chk++; if (bus.ARSIZE_S !== 3'd2) $display("FAIL single_arsize got %0d want 2", bus.ARSIZE_S); else n_pass++;
      n_chk++; if (bus.ARBURST_S !== 2'd1) $display("FAIL single_arburst got %0d want 1", bus.ARBURST_S); else n_pass++;
      step();
      bus.S_ARREADY = 1'b0;
      n_chk++; if (bus.ARVALID_S !== 1'b0) $display("FAIL single_arvalid_drop got %b want 0", bus.ARVALID_S); else n_pass++;
      bus.M0_RREADY = 1'b1;
      bus.S_RVALID = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.S_RDATA = 32'hA0 + 32'(i);
         bus.S_RRESP = 2'(i);
         bus.S_RLAST = (i == 3);
         #1;
         n_chk++; if (bus.RVALID_M0 !== 1'b1) $display("FAIL single_rvalid0 beat%0d got %b want 1", i, bus.RVALID_M0); else n_pass++;
         n_chk++; if (bus.RDATA_M0 !== 32'hA0 + 32'(i)) $display("FAIL single_rdata0 beat%0d got %h want %h", i, bus.RDATA_M0, 32'hA0 + 32'(i)); else n_pass++;
         n_chk++; if (bus.RRESP_M0 !== 2'(i)) $display("FAIL single_rresp0 beat%0d got %0d want %0d", i, bus.RRESP_M0, i); else n_pass++;
         n_chk++; if (bus.RLAST_M0 !== (i == 3)) $display("FAIL single_rlast0 beat%0d got %b want %b", i, bus.RLAST_M0, (i == 3)); else n_pass++;
         n_chk++; if (bus.RVALID_M1 !== 1'b0) $display("FAIL single_rvalid1 beat%0d got %b want 0", i, bus.RVALID_M1); else n_pass++;
         n_chk++; if (bus.RDATA_M1 !== 32'h0) $display("FAIL single_rdata1 beat%0d got %h want 0", i, bus.RDATA_M1); else n_pass++;
         step();
      end
      clear_in();
      #1;
      n_chk++; if (busy !== 1'b0) $display("FAIL single_done_busy got %b want 0", busy); else n_pass++;
      n_chk++; if (len_err !== 1'b0) $display("FAIL single_len_err got %b want 0", len_err); else n_pass++;
      mprio = 1'b1;
   endtask

   task automatic test_contention_lockout();
      do_reset();
      drive_req(0, 1, 32'h10, 4'd0, 3'd2, 2'd1);
      drive_req(1, 1, 32'h20, 4'd0, 3'd2, 2'd1);
      #1;
      n_chk++; if (bus.ARREADY_M0 !== 1'b1) $display("FAIL cont_first_m0 got %b want 1", bus.ARREADY_M0); else n_pass++;
      n_chk++; if (bus.ARREADY_M1 !== 1'b0) $display("FAIL cont_first_m1 got %b want 0", bus.ARREADY_M1); else n_pass++;
      step();
      drop(0);
      #1;
      n_chk++; if (bus.ARREADY_M1 !== 1'b0) $display("FAIL lock_addr_m1 got %b want 0", bus.ARREADY_M1); else n_pass++;
      n_chk++; if (bus.ARADDR_S !== 32'h10) $display("FAIL cont_first_addr got %h want 10", bus.ARADDR_S); else n_pass++;
      addr_phase();
      drive_req(0, 1, 32'h30, 4'd0, 3'd2, 2'd1);
      bus.S_RVALID = 1'b1; bus.S_RLAST = 1'b1; bus.M0_RREADY = 1'b1;
      #1;
      n_chk++; if (bus.ARREADY_M1 !== 1'b0) $display("FAIL lock_rlast_m1 got %b want 0", bus.ARREADY_M1); else n_pass++;
      n_chk++; if (bus.ARREADY_M0 !== 1'b0) $display("FAIL lock_rlast_m0 got %b want 0", bus.ARREADY_M0); else n_pass++;
      step();
      bus.S_RVALID = 1'b0; bus.S_RLAST = 1'b0; bus.M0_RREADY = 1'b0;
      #1;
      n_chk++; if (bus.ARREADY_M1 !== 1'b1) $display("FAIL cont_second_m1 got %b want 1", bus.ARREADY_M1); else n_pass++;
      n_chk++; if (bus.ARREADY_M0 !== 1'b0) $display("FAIL cont_second_m0 got %b want 0", bus.ARREADY_M0); else n_pass++;
      step();
      drop(1);
      #1;
      n_chk++; if (owner !== 1'b1) $display("FAIL cont_second_owner got %b want 1", owner); else n_pass++;
      n_chk++; if (bus.ARADDR_S !== 32'h20) $display("FAIL cont_second_addr got %h want 20", bus.ARADDR_S); else n_pass++;
      addr_phase();
      beats(1, 1, 32'h77);
      #1;
      n_chk++; if (bus.ARREADY_M0 !== 1'b1) $display("FAIL cont_third_m0 got %b want 1", bus.ARREADY_M0); else n_pass++;
      step();
      drop(0);
      addr_phase();
      beats(0, 1, 32'h88);
      // M0 alone is re-granted although priority now favours M1
      drive_req(0, 1, 32'h40, 4'd0, 3'd2, 2'd1);
      #1;
      n_chk++; if (bus.ARREADY_M0 !== 1'b1) $display("FAIL cont_lone_m0 got %b want 1", bus.ARREADY_M0); else n_pass++;
      step();
      drop(0);
      addr_phase();
      beats(0, 1, 32'h99);
      clear_in();
      mprio = 1'b1;
   endtask

   task automatic test_backpressure();
      do_reset();
      drive_req(1, 1, 32'hCAFE_0040, 4'd1, 3'd1, 2'd2);
      step();
      drop(1);
      for (int i = 0; i < 5; i++) begin
         #1;
         n_chk++; if (bus.ARVALID_S !== 1'b1) $display("FAIL bp_arvalid cyc%0d got %b want 1", i, bus.ARVALID_S); else n_pass++;
         n_chk++; if (bus.ARADDR_S !== 32'hCAFE_0040) $display("FAIL bp_araddr cyc%0d got %h want cafe0040", i, bus.ARADDR_S); else n_pass++;
         n_chk++; if (bus.ARLEN_S !== 4'd1) $display("FAIL bp_arlen cyc%0d got %0d want 1", i, bus.ARLEN_S); else n_pass++;
         step();
      end
      addr_phase();
      bus.S_RVALID = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.M1_RREADY = (i % 2 == 0);
         bus.S_RDATA = 32'(i);
         bus.S_RLAST = (i >= 2);
         #1;
         n_chk++; if (bus.RREADY_S !== bus.M1_RREADY) $display("FAIL bp_rready cyc%0d got %b want %b", i, bus.RREADY_S, bus.M1_RREADY); else n_pass++;
         if (i < 3) begin
            n_chk++; if (bus.RVALID_M1 !== 1'b1) $display("FAIL bp_rvalid1 cyc%0d got %b want 1", i, bus.RVALID_M1); else n_pass++;
         end
         step();
      end
      clear_in();
      n_chk++; if (busy !== 1'b0) $display("FAIL bp_done_busy got %b want 0", busy); else n_pass++;
      mprio = 1'b0;
   endtask

   task automatic test_len_err();
      do_reset();
      drive_req(0, 1, 32'h300, 4'd3, 3'd2, 2'd1);
      step(); drop(0); addr_phase();
      beats(0, 2, 32'h50);
      n_chk++; if (busy !== 1'b0) $display("FAIL short_busy got %b want 0", busy); else n_pass++;
      n_chk++; if (len_err !== 1'b1) $display("FAIL short_len_err got %b want 1", len_err); else n_pass++;
      step();
      n_chk++; if (len_err !== 1'b0) $display("FAIL short_len_err_pulse got %b want 0", len_err); else n_pass++;
      drive_req(1, 1, 32'h400, 4'd0, 3'd2, 2'd1);
      step(); drop(1); addr_phase();
      bus.M1_RREADY = 1'b1; bus.S_RVALID = 1'b1; bus.S_RDATA = 32'h61;
      step();
      n_chk++; if (busy !== 1'b1) $display("FAIL long_busy got %b want 1", busy); else n_pass++;
      bus.S_RDATA = 32'h62; bus.S_RLAST = 1'b1;
      #1;
      n_chk++; if (bus.RDATA_M1 !== 32'h62) $display("FAIL long_rdata got %h want 62", bus.RDATA_M1); else n_pass++;
      step();
      clear_in();
      n_chk++; if (len_err !== 1'b1) $display("FAIL long_len_err got %b want 1", len_err); else n_pass++;
      step();
      n_chk++; if (len_err !== 1'b0) $display("FAIL long_len_err_pulse got %b want 0", len_err); else n_pass++;
      mprio = 1'b0;
   endtask

   task automatic test_random();
      do_reset();
      for (int b = 0; b < 40; b++) begin
         logic        v0, v1, w, sv, r0, r1, rdy, rv, rl, orv;
         logic [31:0] a[2];
         logic [3:0]  l[2];
         logic [2:0]  sz[2];
         logic [1:0]  bt[2];
         logic [31:0] d, rd;
         logic [1:0]  rs, rr;
         int          nb, got, cyc, wt;
         do begin
            v0 = 1'($urandom_range(1));
            v1 = 1'($urandom_range(1));
         end while (!(v0 || v1));
         for (int m = 0; m < 2; m++) begin
            a[m] = $urandom; l[m] = 4'($urandom_range(15));
            sz[m] = 3'($urandom_range(7)); bt[m] = 2'($urandom_range(2));
         end
         drive_req(0, v0, a[0], l[0], sz[0], bt[0]);
         drive_req(1, v1, a[1], l[1], sz[1], bt[1]);
         w = (v0 && v1) ? mprio : v1;
         #1;
         n_chk++; if (bus.ARREADY_M0 !== !w) $display("FAIL rnd%0d arready0 got %b want %b", b, bus.ARREADY_M0, !w); else n_pass++;
         n_chk++; if (bus.ARREADY_M1 !== w) $display("FAIL rnd%0d arready1 got %b want %b", b, bus.ARREADY_M1, w); else n_pass++;
         step();
         drop(w);
         #1;
         n_chk++; if (owner !== w) $display("FAIL rnd%0d owner got %b want %b", b, owner, w); else n_pass++;
         n_chk++; if (len_err !== 1'b0) $display("FAIL rnd%0d len_err_idle got %b want 0", b, len_err); else n_pass++;
         wt = $urandom_range(3);
         for (int c = 0; c <= wt; c++) begin
            n_chk++; if (bus.ARVALID_S !== 1'b1 || bus.ARADDR_S !== a[w] || bus.ARLEN_S !== l[w] || bus.ARSIZE_S !== sz[w] || bus.ARBURST_S !== bt[w])
               $display("FAIL rnd%0d ar_s got %b/%h/%0d/%0d/%0d want 1/%h/%0d/%0d/%0d", b, bus.ARVALID_S, bus.ARADDR_S, bus.ARLEN_S, bus.ARSIZE_S, bus.ARBURST_S, a[w], l[w], sz[w], bt[w]);
            else n_pass++;
            if (c == wt) bus.S_ARREADY = 1'b1;
            step();
         end
         bus.S_ARREADY = 1'b0;
         nb = int'(l[w]) + 1;
         case ($urandom_range(7))
            0: nb = nb + 1;
            1: if (nb > 1) nb = nb - 1;
            default: ;
         endcase
         got = 0;
         cyc = 0;
         while (got < nb && cyc < 300) begin
            sv = ($urandom_range(3) != 0);
            r0 = ($urandom_range(3) != 0);
            r1 = ($urandom_range(3) != 0);
            d = $urandom;
            rs = 2'($urandom_range(3));
            bus.S_RVALID = sv; bus.S_RDATA = d; bus.S_RRESP = rs;
            bus.S_RLAST = (got == nb - 1);
            bus.M0_RREADY = r0; bus.M1_RREADY = r1;
            #1;
            rdy = w ? r1 : r0;
            rv  = w ? bus.RVALID_M1 : bus.RVALID_M0;
            rl  = w ? bus.RLAST_M1 : bus.RLAST_M0;
            rd  = w ? bus.RDATA_M1 : bus.RDATA_M0;
            rr  = w ? bus.RRESP_M1 : bus.RRESP_M0;
            orv = w ? bus.RVALID_M0 : bus.RVALID_M1;
            n_chk++; if (bus.RREADY_S !== rdy) $display("FAIL rnd%0d rready_s got %b want %b", b, bus.RREADY_S, rdy); else n_pass++;
            n_chk++; if (rv !== sv || orv !== 1'b0) $display("FAIL rnd%0d rvalid got %b/%b want %b/0", b, rv, orv, sv); else n_pass++;
            if (sv) begin
               n_chk++; if (rd !== d || rr !== rs || rl !== (got == nb - 1))
                  $display("FAIL rnd%0d rbeat got %h/%0d/%b want %h/%0d/%b", b, rd, rr, rl, d, rs, (got == nb - 1));
               else n_pass++;
            end
            n_chk++; if ((w ? bus.ARREADY_M0 : bus.ARREADY_M1) !== 1'b0) $display("FAIL rnd%0d lockout got 1 want 0", b); else n_pass++;
            if (sv && rdy) got++;
            step();
            cyc++;
         end
         if (got < nb) begin
            n_chk++;
            $display("FAIL rnd%0d burst_timeout got %0d beats want %0d", b, got, nb);
         end
         bus.S_RVALID = 1'b0; bus.S_RLAST = 1'b0;
         bus.M0_RREADY = 1'b0; bus.M1_RREADY = 1'b0;
         n_chk++; if (busy !== 1'b0) $display("FAIL rnd%0d end_busy got %b want 0", b, busy); else n_pass++;
         n_chk++; if (len_err !== (nb != int'(l[w]) + 1)) $display("FAIL rnd%0d len_err got %b want %b", b, len_err, (nb != int'(l[w]) + 1)); else n_pass++;
         mprio = !w;
      end
      clear_in();
      step();
      n_chk++; if (len_err !== 1'b0) $display("FAIL rnd_final_len_err got %b want 0", len_err); else n_pass++;
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      mprio = 1'b0;
      G_reset = 1'b0;
      clear_in();
      test_reset();
      test_single();
      test_contention_lockout();
      test_backpressure();
      test_len_err();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Two-master to one-slave AXI4 read-channel arbiter for the read-only interconnect path.
- Accepts AR requests from M0/M1 using round-robin priority and forwards the winning request to the slave port.
- Owns the slave until the last R beat of that burst, routes R beats back to the owner only, and checks burst length against ARLEN.
- Sits between the master-side AR/R ports and one slave-side AR/R port; the interconnect instantiates one per slave.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, read data width
- LEN_W, 4, ARLEN width (burst beats = ARLEN+1)

Ports:
- G_clk  in  1  clock
- G_reset  in  1  asynchronous active-low reset
- M0_ARADDR / M1_ARADDR  in  ADDR_W  request address
- M0_ARLEN / M1_ARLEN  in  LEN_W  burst length-1
- M0_ARSIZE / M1_ARSIZE  in  3  beat size
- M0_ARBURST / M1_ARBURST  in  2  burst type
- M0_ARVALID / M1_ARVALID  in  1  request valid
- ARREADY_M0 / ARREADY_M1  out  1  request accepted
- RDATA_M0 / RDATA_M1  out  DATA_W  read data to master
- RRESP_M0 / RRESP_M1  out  2  read response to master
- RLAST_M0 / RLAST_M1  out  1  last beat to master
- RVALID_M0 / RVALID_M1  out  1  beat valid to master
- M0_RREADY / M1_RREADY  in  1  master ready
- ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S  out  ADDR_W/LEN_W/3/2  forwarded request
- ARVALID_S  out  1  request valid to slave
- S_ARREADY  in  1  slave accepts request
- S_RDATA, S_RRESP, S_RLAST, S_RVALID  in  DATA_W/2/1/1  slave R channel
- RREADY_S  out  1  ready to slave
- owner  out  1  current/last granted master
- busy  out  1  high in ADDR or DATA state
- len_err  out  1  one-cycle pulse on burst-length mismatch

Behaviour:
- Clock and reset: one clock, G_clk. Reset G_reset is asynchronous, active-low.
- Reset values: state=IDLE; owner=0; prio=0 (M0 preferred); beat counter=0; ARVALID_S=0; AR payload regs=0; len_err=0.
- Reset values of combinational outputs: ARREADY_Mx=0, RVALID_Mx=0, RLAST_Mx=0, RREADY_S=0, busy=0.
- Reset asserted mid-burst: abandon the burst immediately; in-flight slave beats after release are dropped with RREADY_S=0.
- FSM states: IDLE, ADDR, DATA.
- IDLE, arbitration:
  - Winner is the only valid requester.
  - If both are valid, winner = prio.
  - ARREADY_M<winner>=1 combinationally in IDLE only; the loser's ARREADY is 0.
- IDLE, request accept (ARVALID&&ARREADY):
  - Latch ARADDR/ARLEN/ARSIZE/ARBURST into the AR_S regs.
  - owner<=winner; beat counter<=0.
  - ARVALID_S<=1; go to ADDR.
  - Slave sees ARVALID_S one cycle after the master handshake.
- ADDR:
  - Hold ARVALID_S and payload stable until S_ARREADY=1.
  - On S_ARREADY: ARVALID_S<=0; go to DATA.
  - No timeout.
- DATA routing:
  - RVALID_M<owner>=S_RVALID; RDATA/RRESP/RLAST of the owner follow the S_ inputs.
  - RREADY_S=M<owner>_RREADY.
  - Non-owner RVALID=0, RLAST=0; non-owner RDATA/RRESP are driven 0.
- DATA beat counting:
  - A beat is S_RVALID&&RREADY_S.
  - Each beat increments the counter (LEN_W+1 bits, no wrap within a legal burst).
- DATA end of burst, on a beat with S_RLAST=1:
  - Go to IDLE; prio<=~owner.
  - If counter != latched ARLEN, len_err pulses 1 the next cycle.
- Excess beats: if the counter reaches ARLEN without S_RLAST, continue passing beats. len_err pulses at the eventual RLAST; the FSM does not force termination.
- Non-blocking rule: no new AR is accepted outside IDLE (one outstanding burst). The next arbitration happens in the cycle after RLAST.
- Simultaneous events:
  - Both valid with prio=1: M1 is granted.
  - A master deasserting ARVALID before its handshake is legal; no state change.
- Idle request after burst: a single requester continuously valid is re-granted every burst even if prio points elsewhere.
- busy=(state!=IDLE). owner holds its value in IDLE.

Test Plan:
- Reset: G_reset=0 mid-DATA for 1 cycle → state IDLE, ARVALID_S=0, RREADY_S=0, owner=0, prio=0 after release.
- Single request: M0 ARADDR=0x0000_1000, ARLEN=3, ARVALID=1 while S_ARREADY=1 → ARREADY_M0 in cycle 0; ARVALID_S=1 with ARADDR_S=0x1000, ARLEN_S=3 in cycle 1; 4 beats 0xA0..0xA3 reach RDATA_M0 with RLAST on the 4th; RVALID_M1 stays 0.
- Contention: M0 and M1 both valid at reset → M0 granted first (ARLEN=0). After RLAST, M1 is granted with M0 still valid. M0 is then granted third.
- Backpressure:
  - S_ARREADY held 0 for 5 cycles → ARVALID_S and payload stable for 5 cycles.
  - M1_RREADY toggles 1,0,1,0 during an M1 burst → RREADY_S mirrors it; beats counted only when both ready and valid.
- Length error: ARLEN=3, slave asserts RLAST on beat 2 → FSM returns to IDLE, len_err=1 for exactly one cycle.
- Lock-out: M1 ARVALID asserted during an M0 burst in ADDR/DATA → ARREADY_M1=0 until the cycle after M0's RLAST beat.
